// File: rtl/cjb_nbit_ret_stack_v.sv
`default_nettype none
// ============================================================================
// Module      : cjb_nbit_ret_stack_v
// Description : n-bit return-address LIFO for CALL/RET with sticky
//               overflow/underflow flags; top feeds the PC-select mux.
// Revision    : 1.0 - initial release
// ============================================================================
module cjb_nbit_ret_stack_v #(
    parameter int n     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [n-1:0]  push_data,
    input  logic          clr_err,
    output logic [n-1:0]  top,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_idx_one = AW'(1);
    localparam logic [AW-1:0] c_idx_two = AW'(2);

    logic [n-1:0]  mem_q [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [n-1:0]  top_q,   top_d;
    logic          ovf_q,   ovf_d;
    logic          unf_q,   unf_d;

    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_idx_m1;
    logic [AW-1:0] w_idx_m2;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == c_depth);
    // Modular index arithmetic: when full, w_idx wraps to 0 so idx-1 lands on DEPTH-1.
    assign w_idx    = count_q[AW-1:0];
    assign w_idx_m1 = w_idx - c_idx_one;
    assign w_idx_m2 = w_idx - c_idx_two;

    always_comb begin
        count_d  = count_q;
        top_d    = top_q;
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        unf_d    = clr_err ? 1'b0 : unf_q;
        w_wr_en  = 1'b0;
        w_wr_idx = w_idx;
        case ({push, pop})
            2'b10: begin
                if (w_full) begin
                    ovf_d = 1'b1;
                end else begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_idx;
                    count_d  = count_q + c_cnt_one;
                    top_d    = push_data;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    unf_d = 1'b1;
                end else if (count_q == c_cnt_one) begin
                    count_d = '0;
                    top_d   = '0;
                end else begin
                    count_d = count_q - c_cnt_one;
                    top_d   = mem_q[w_idx_m2];
                end
            end
            2'b11: begin
                // Push+pop replaces the top entry; on an empty stack it is a plain push.
                w_wr_en = 1'b1;
                top_d   = push_data;
                if (w_empty) begin
                    w_wr_idx = '0;
                    count_d  = c_cnt_one;
                end else begin
                    w_wr_idx = w_idx_m1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top     = top_q;
    assign count   = count_q;
    assign empty   = w_empty;
    assign full    = w_full;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_cjb_nbit_ret_stack_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_cjb_nbit_ret_stack_v
// Description : Self-checking bench for the return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cjb_nbit_ret_stack_v;

    logic       clk;
    logic       resetn;
    logic       push;
    logic       pop;
    logic [7:0] push_data;
    logic       clr_err;
    logic [7:0] top;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       ovf_err;
    logic       unf_err;

    int n_checks;
    int n_pass;

    cjb_nbit_ret_stack_v #(.n(8), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are read at the same point.
    task automatic step(input logic p, input logic po, input logic [7:0] d, input logic c);
        push      = p;
        pop       = po;
        push_data = d;
        clr_err   = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        push = 0; pop = 0; push_data = 0; clr_err = 0;
        do_reset();
        n_checks++; if (top !== 8'h00) $display("FAIL reset_top: got %h want 00", top); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if ({empty, full, ovf_err, unf_err} !== 4'b1000)
            $display("FAIL reset_flags: got e/f/o/u=%b want 1000", {empty, full, ovf_err, unf_err}); else n_pass++;
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        push = 1'b1; push_data = 8'h33;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if ({top, count, empty, full, ovf_err, unf_err} !== {8'h00, 4'd0, 4'b1000})
            $display("FAIL reset_async: got top=%h cnt=%0d e/f/o/u=%b want 00/0/1000",
                     top, count, {empty, full, ovf_err, unf_err}); else n_pass++;
        push = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lifo();
        logic [7:0] exp_top [3];
        exp_top[0] = 8'h20; exp_top[1] = 8'h10; exp_top[2] = 8'h00;
        step(1, 0, 8'h10, 0);
        step(1, 0, 8'h20, 0);
        step(1, 0, 8'h30, 0);
        n_checks++; if (top !== 8'h30 || count !== 4'd3)
            $display("FAIL lifo_push: got top=%h cnt=%0d want 30/3", top, count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00, 0);
            n_checks++; if (top !== exp_top[i] || count !== 4'(2 - i))
                $display("FAIL lifo_pop%0d: got top=%h cnt=%0d want %h/%0d", i, top, count, exp_top[i], 2 - i);
            else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL lifo_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0);
        n_checks++; if (full !== 1'b1 || top !== 8'h08)
            $display("FAIL ovf_fill: got full=%b top=%h want 1/08", full, top); else n_pass++;
        step(1, 0, 8'hFF, 0);
        n_checks++; if (count !== 4'd8 || top !== 8'h08 || ovf_err !== 1'b1)
            $display("FAIL ovf_push: got cnt=%0d top=%h ovf=%b want 8/08/1", count, top, ovf_err); else n_pass++;
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, 8'h00, 0);
            n_checks++; if (top !== 8'(i) || count !== 4'(i))
                $display("FAIL ovf_pop%0d: got top=%h cnt=%0d want %h/%0d", i, top, count, 8'(i), i);
            else n_pass++;
        end
        step(0, 0, 8'h00, 1);
        n_checks++; if (ovf_err !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf_err); else n_pass++;
    endtask

    task automatic test_underflow();
        step(0, 1, 8'h00, 0);
        n_checks++; if (unf_err !== 1'b1 || count !== 4'd0 || top !== 8'h00)
            $display("FAIL unf_pop: got unf=%b cnt=%0d top=%h want 1/0/00", unf_err, count, top); else n_pass++;
        step(0, 0, 8'h00, 1);
        n_checks++; if (unf_err !== 1'b0) $display("FAIL unf_clear: got %b want 0", unf_err); else n_pass++;
        step(0, 1, 8'h00, 1);
        n_checks++; if (unf_err !== 1'b1) $display("FAIL unf_clr_race: got %b want 1", unf_err); else n_pass++;
        step(0, 0, 8'h00, 1);
    endtask

    task automatic test_simultaneous();
        step(1, 0, 8'hA0, 0);
        step(1, 1, 8'hB0, 0);
        n_checks++; if (count !== 4'd1 || top !== 8'hB0)
            $display("FAIL sim_replace: got cnt=%0d top=%h want 1/B0", count, top); else n_pass++;
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h40 + i), 0);
        step(1, 1, 8'hCC, 0);
        n_checks++; if (count !== 4'd8 || top !== 8'hCC || ovf_err !== 1'b0)
            $display("FAIL sim_full: got cnt=%0d top=%h ovf=%b want 8/CC/0", count, top, ovf_err); else n_pass++;
        step(0, 1, 8'h00, 0);
        n_checks++; if (top !== 8'h45) $display("FAIL sim_full_pop: got %h want 45", top); else n_pass++;
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0);
        step(1, 1, 8'h55, 0);
        n_checks++; if (count !== 4'd1 || top !== 8'h55 || unf_err !== 1'b0)
            $display("FAIL sim_empty: got cnt=%0d top=%h unf=%b want 1/55/0", count, top, unf_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       m_ovf;
        logic       m_unf;
        logic       p, po, c;
        logic [7:0] d;
        logic [7:0] e_top;
        int         fails;
        do_reset();
        m_ovf = 0;
        m_unf = 0;
        fails = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            p  = ($urandom_range(99) < 50);
            po = ($urandom_range(99) < 45);
            c  = ($urandom_range(99) < 8);
            d  = 8'($urandom);
            step(p, po, d, c);
            if (c) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (p && po) begin
                if (q.size() == 0) q.push_back(d);
                else q[q.size()-1] = d;
            end else if (p) begin
                if (q.size() == 8) m_ovf = 1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) m_unf = 1;
                else void'(q.pop_back());
            end
            e_top = (q.size() > 0) ? q[q.size()-1] : 8'h00;
            n_checks++;
            if (top !== e_top || count !== 4'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == 8) || ovf_err !== m_ovf || unf_err !== m_unf) begin
                if (fails < 10)
                    $display("FAIL rand_cyc%0d: got top=%h cnt=%0d e/f/o/u=%b want top=%h cnt=%0d e/f/o/u=%b",
                             cyc, top, count, {empty, full, ovf_err, unf_err}, e_top, q.size(),
                             {q.size() == 0, q.size() == 8, m_ovf, m_unf});
                fails++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b0;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
